// File: rtl/detector_jogada.sv
// detector_jogada: debounces the 64-square occupancy sensors and tracks
// lift/place events until one complete move exists. The move is then held
// on jogada/captura with temJogada high until the control unit consumes it.
//
// Handshake: temJogada is a level that stays high while a move is pending.
// jogada and captura are stable for as long as temJogada is high. The
// consumer acknowledges with a one-cycle consome pulse, and temJogada drops
// on the following cycle. consome while temJogada is low has no effect.
module detector_jogada #(
    parameter int ESTAVEL_CICLOS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        habilita,
    input  logic [63:0] tabuleiro,
    input  logic        consome,
    input  logic        limpar,
    output logic        temJogada,
    output logic [11:0] jogada,
    output logic        captura,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int            CW      = $clog2(ESTAVEL_CICLOS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(ESTAVEL_CICLOS);

    // State codes double as the debug display value
    typedef enum logic [3:0] {
        ST_OCIOSO    = 4'h0,
        ST_AGUARDA   = 4'h1,
        ST_LEVANTADA = 4'h2,
        ST_CAPTURA   = 4'h3,
        ST_PRONTA    = 4'h4,
        ST_ERRO      = 4'hF
    } estado_t;

    estado_t       estado, estado_nxt;

    logic [63:0]   raw_q;
    logic [63:0]   snap;
    logic [63:0]   referencia;
    logic [CW-1:0] cnt;
    logic          novo;

    logic [63:0]   vaga, ocupa, mudou;
    logic          um_bit, single_vaga, single_ocupa;
    logic [5:0]    idx;

    logic [5:0]    origem, capt;
    logic [11:0]   jogada_q;
    logic          captura_q;

    logic          ld_ref, ld_origem, ld_capt, ld_pronta, pronta_capt;

    // Debounce: a raw pattern must hold ESTAVEL_CICLOS cycles before it
    // replaces the stable snapshot; novo marks the cycle after the update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            raw_q <= '0;
            cnt   <= '0;
            snap  <= '0;
            novo  <= 1'b0;
        end else begin
            raw_q <= tabuleiro;
            novo  <= 1'b0;
            if (tabuleiro != raw_q) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (cnt == CNT_MAX && raw_q != snap) begin
                snap <= raw_q;
                novo <= 1'b1;
            end
        end
    end

    assign vaga   = referencia & ~snap;
    assign ocupa  = ~referencia & snap;
    assign mudou  = vaga | ocupa;
    // Exactly one square changed; vaga and ocupa are disjoint, so that bit
    // lives in exactly one of them
    assign um_bit       = (mudou != 64'd0) && ((mudou & (mudou - 64'd1)) == 64'd0);
    assign single_vaga  = um_bit && (vaga != 64'd0);
    assign single_ocupa = um_bit && (ocupa != 64'd0);

    // Index of the changed square (only meaningful when um_bit is set)
    always_comb begin
        idx = '0;
        for (int i = 0; i < 64; i++) begin
            if (mudou[i]) idx = 6'(i);
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= ST_OCIOSO;
        else       estado <= estado_nxt;
    end

    // Next-state and datapath load decisions; habilita low wins over all
    always_comb begin
        estado_nxt  = estado;
        ld_ref      = 1'b0;
        ld_origem   = 1'b0;
        ld_capt     = 1'b0;
        ld_pronta   = 1'b0;
        pronta_capt = 1'b0;
        if (!habilita) begin
            estado_nxt = ST_OCIOSO;
        end else begin
            case (estado)
                ST_OCIOSO: estado_nxt = ST_AGUARDA;
                ST_AGUARDA: begin
                    if (novo) begin
                        if (single_vaga) begin
                            ld_origem  = 1'b1;
                            ld_ref     = 1'b1;
                            estado_nxt = ST_LEVANTADA;
                        end else begin
                            estado_nxt = ST_ERRO;
                        end
                    end
                end
                ST_LEVANTADA: begin
                    if (novo) begin
                        if (single_vaga) begin
                            ld_capt    = 1'b1;
                            ld_ref     = 1'b1;
                            estado_nxt = ST_CAPTURA;
                        end else if (single_ocupa && idx == origem) begin
                            ld_ref     = 1'b1;
                            estado_nxt = ST_AGUARDA;
                        end else if (single_ocupa) begin
                            ld_pronta  = 1'b1;
                            ld_ref     = 1'b1;
                            estado_nxt = ST_PRONTA;
                        end else begin
                            estado_nxt = ST_ERRO;
                        end
                    end
                end
                ST_CAPTURA: begin
                    if (novo) begin
                        if (single_ocupa && idx == capt) begin
                            ld_pronta   = 1'b1;
                            pronta_capt = 1'b1;
                            ld_ref      = 1'b1;
                            estado_nxt  = ST_PRONTA;
                        end else begin
                            estado_nxt = ST_ERRO;
                        end
                    end
                end
                // Board changes are deliberately not absorbed here; they
                // surface as a multi-square diff once back in AGUARDA
                ST_PRONTA: begin
                    if (consome) estado_nxt = ST_AGUARDA;
                end
                ST_ERRO: begin
                    if (limpar) begin
                        ld_ref     = 1'b1;
                        estado_nxt = ST_AGUARDA;
                    end
                end
                default: estado_nxt = ST_OCIOSO;
            endcase
        end
    end

    // Move registers; the reference board tracks the snapshot while idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            referencia <= '0;
            origem     <= '0;
            capt       <= '0;
            jogada_q   <= '0;
            captura_q  <= 1'b0;
        end else begin
            if (ld_ref || estado == ST_OCIOSO) referencia <= snap;
            if (ld_origem) origem <= idx;
            if (ld_capt)   capt   <= idx;
            if (ld_pronta) begin
                jogada_q  <= {origem, idx};
                captura_q <= pronta_capt;
            end
        end
    end

    // Outputs decoded from state; captura only shows with a pending move
    always_comb begin
        temJogada = (estado == ST_PRONTA);
        erro      = (estado == ST_ERRO);
        db_estado = estado;
        jogada    = jogada_q;
        captura   = captura_q && (estado == ST_PRONTA);
    end

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed board sequences, a move-level model
// checked every cycle, and literal expectations at key points.
module tb_detector_jogada;

    localparam int          E      = 4;
    localparam logic [63:0] INICIO = 64'hFFFF_0000_0000_FFFF;

    localparam int P_IDLE   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_LIFTED = 2;
    localparam int P_TAKEN  = 3;
    localparam int P_READY  = 4;
    localparam int P_ERR    = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        habilita;
    logic [63:0] tabuleiro;
    logic        consome;
    logic        limpar;
    logic        temJogada;
    logic [11:0] jogada;
    logic        captura;
    logic        erro;
    logic [3:0]  db_estado;

    int errors = 0;
    int checks = 0;

    detector_jogada #(.ESTAVEL_CICLOS(E)) dut (
        .clock     (clock),
        .reset     (reset),
        .habilita  (habilita),
        .tabuleiro (tabuleiro),
        .consome   (consome),
        .limpar    (limpar),
        .temJogada (temJogada),
        .jogada    (jogada),
        .captura   (captura),
        .erro      (erro),
        .db_estado (db_estado)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- move-level model ----------------
    int          m_phase;
    int          m_cyc;
    int          m_last_change;
    logic [63:0] m_raw, m_snap, m_ref;
    bit          m_novo;
    int          m_from, m_taken;
    logic [11:0] m_jogada;
    bit          m_captura;

    logic [63:0] lifted, placed;
    int          nl, np, sq, nxt;
    bit          fire;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase       = P_IDLE;
            m_raw         = '0;
            m_snap        = '0;
            m_ref         = '0;
            m_novo        = 0;
            m_last_change = m_cyc;
            m_from        = 0;
            m_taken       = 0;
            m_jogada      = '0;
            m_captura     = 0;
        end else begin
            m_cyc++;
            lifted = m_ref & ~m_snap;
            placed = ~m_ref & m_snap;
            nl = $countones(lifted);
            np = $countones(placed);
            sq = 0;
            for (int i = 0; i < 64; i++) if (lifted[i] || placed[i]) sq = i;
            nxt = m_phase;
            if (m_phase == P_IDLE) m_ref = m_snap;
            if (!habilita) begin
                nxt = P_IDLE;
            end else begin
                case (m_phase)
                    P_IDLE: nxt = P_WAIT;
                    P_WAIT: if (m_novo) begin
                        if (nl == 1 && np == 0) begin
                            m_from = sq; m_ref = m_snap; nxt = P_LIFTED;
                        end else nxt = P_ERR;
                    end
                    P_LIFTED: if (m_novo) begin
                        if (nl == 1 && np == 0) begin
                            m_taken = sq; m_ref = m_snap; nxt = P_TAKEN;
                        end else if (np == 1 && nl == 0) begin
                            m_ref = m_snap;
                            if (sq == m_from) nxt = P_WAIT;
                            else begin
                                m_jogada = {6'(m_from), 6'(sq)}; m_captura = 0; nxt = P_READY;
                            end
                        end else nxt = P_ERR;
                    end
                    P_TAKEN: if (m_novo) begin
                        if (np == 1 && nl == 0 && sq == m_taken) begin
                            m_jogada = {6'(m_from), 6'(sq)}; m_captura = 1;
                            m_ref = m_snap; nxt = P_READY;
                        end else nxt = P_ERR;
                    end
                    P_READY: if (consome) nxt = P_WAIT;
                    P_ERR: if (limpar) begin
                        m_ref = m_snap; nxt = P_WAIT;
                    end
                    default: nxt = P_IDLE;
                endcase
            end
            if (nxt != P_READY) m_captura = 0;
            // raw pattern accepted once it has been held for E full cycles
            fire = ((m_cyc - 1 - m_last_change) >= E) && (m_raw != m_snap);
            if (tabuleiro != m_raw) m_last_change = m_cyc;
            m_novo = fire;
            if (fire) m_snap = m_raw;
            m_raw = tabuleiro;
            m_phase = nxt;
        end
    end

    // ---------------- per-cycle scoreboard compare ----------------
    always @(negedge clock) begin
        check("temJogada", {63'd0, temJogada}, {63'd0, m_phase == P_READY});
        check("erro", {63'd0, erro}, {63'd0, m_phase == P_ERR});
        check("db_estado", {60'd0, db_estado}, {60'd0, 4'(m_phase)});
        check("captura", {63'd0, captura}, {63'd0, m_captura});
        check("jogada", {52'd0, jogada}, {52'd0, m_jogada});
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_consome();
        consome = 1'b1;
        cycles(1);
        consome = 1'b0;
    endtask

    task automatic pulse_limpar();
        limpar = 1'b1;
        cycles(1);
        limpar = 1'b0;
    endtask

    task automatic wait_tem(output int n);
        n = 0;
        do begin
            cycles(1);
            n++;
        end while (!temJogada && n < 40);
        check("wait_temJogada", {63'd0, temJogada}, 64'd1);
    endtask

    int lat;
    int seen;

    initial begin
        reset     = 1'b1;
        habilita  = 1'b0;
        consome   = 1'b0;
        limpar    = 1'b0;
        tabuleiro = INICIO;
        cycles(3);
        check("reset_tem", {63'd0, temJogada}, 64'd0);
        check("reset_jogada", {52'd0, jogada}, 64'd0);
        check("reset_erro", {63'd0, erro}, 64'd0);
        check("reset_estado", {60'd0, db_estado}, 64'd0);
        reset = 1'b0;
        cycles(10);
        check("idle_estado", {60'd0, db_estado}, 64'h0);
        habilita = 1'b1;
        cycles(12);
        check("aguarda_estado", {60'd0, db_estado}, 64'h1);

        // plain move 12 -> 28 with latency check
        tabuleiro[12] = 1'b0;
        cycles(8);
        check("lift_estado", {60'd0, db_estado}, 64'h2);
        tabuleiro[28] = 1'b1;
        wait_tem(lat);
        check("latency", 64'(lat), 64'(E + 3));
        check("move1_jogada", {52'd0, jogada}, {52'd0, 12'o1434});
        check("move1_captura", {63'd0, captura}, 64'd0);
        pulse_consome();
        check("move1_consumed", {63'd0, temJogada}, 64'd0);

        // move back 28 -> 12
        tabuleiro[28] = 1'b0;
        cycles(8);
        tabuleiro[12] = 1'b1;
        wait_tem(lat);
        check("move2_jogada", {52'd0, jogada}, {52'd0, 12'o3414});
        pulse_consome();

        // short glitch never reaches the FSM
        tabuleiro[12] = 1'b0;
        cycles(2);
        tabuleiro[12] = 1'b1;
        cycles(12);
        check("glitch_estado", {60'd0, db_estado}, 64'h1);

        // piece put back on its origin: cancelled
        tabuleiro[12] = 1'b0;
        cycles(8);
        check("cancel_lift", {60'd0, db_estado}, 64'h2);
        tabuleiro[12] = 1'b1;
        seen = 0;
        repeat (10) begin
            cycles(1);
            if (temJogada) seen++;
        end
        check("cancel_no_tem", 64'(seen), 64'd0);
        check("cancel_estado", {60'd0, db_estado}, 64'h1);

        // consome and limpar outside their states are ignored
        pulse_consome();
        pulse_limpar();
        cycles(2);
        check("ignored_pulses", {60'd0, db_estado}, 64'h1);

        // capture 12 x 51
        tabuleiro[12] = 1'b0;
        cycles(8);
        tabuleiro[51] = 1'b0;
        cycles(8);
        check("capt_estado", {60'd0, db_estado}, 64'h3);
        tabuleiro[51] = 1'b1;
        wait_tem(lat);
        check("capt_jogada", {52'd0, jogada}, {52'd0, 12'o1463});
        check("capt_captura", {63'd0, captura}, 64'd1);

        // disable while a move is pending
        habilita = 1'b0;
        cycles(1);
        check("dis_tem", {63'd0, temJogada}, 64'd0);
        check("dis_captura", {63'd0, captura}, 64'd0);
        check("dis_jogada_kept", {52'd0, jogada}, {52'd0, 12'o1463});
        check("dis_estado", {60'd0, db_estado}, 64'h0);
        tabuleiro = INICIO;
        cycles(10);
        habilita = 1'b1;
        cycles(3);

        // two squares at once -> error, then recover
        tabuleiro[12] = 1'b0;
        tabuleiro[13] = 1'b0;
        cycles(8);
        check("err_erro", {63'd0, erro}, 64'd1);
        check("err_estado", {60'd0, db_estado}, 64'hF);
        pulse_limpar();
        check("clr_erro", {63'd0, erro}, 64'd0);
        check("clr_estado", {60'd0, db_estado}, 64'h1);
        tabuleiro[11] = 1'b0;
        cycles(8);
        tabuleiro[19] = 1'b1;
        wait_tem(lat);
        check("move3_jogada", {52'd0, jogada}, {52'd0, 12'o1323});
        pulse_consome();

        // reset in the middle of a lift
        tabuleiro[14] = 1'b0;
        cycles(8);
        check("pre_reset_estado", {60'd0, db_estado}, 64'h2);
        #3 reset = 1'b1;
        #1;
        check("async_tem", {63'd0, temJogada}, 64'd0);
        check("async_jogada", {52'd0, jogada}, 64'd0);
        check("async_estado", {60'd0, db_estado}, 64'h0);
        habilita = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(10);
        habilita = 1'b1;
        cycles(3);
        tabuleiro[20] = 1'b1;
        cycles(8);
        check("place_only_erro", {63'd0, erro}, 64'd1);
        check("place_only_estado", {60'd0, db_estado}, 64'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
